datain_pkt_rx: RTL and testbench
================================

Name: datain_pkt_rx

Overview:
Parametrised packet receiver for the datain stream: `packet_valid` plus a `BW`-bit `data_in` bus. It parses the header for destination and length, and buffers each packet into one of `NUM_CH` per-channel FIFOs. It checks trailing parity, and commits a packet atomically, so downstream sees whole packets only. It sits between the datain agent's DUT-side pins and the channel readers, replacing the fixed 8-bit single-format input stage.

Parameters:
BW, 8, data word width; header and parity are also BW bits.
NUM_CH, 3, number of destination channels (2..16).
FIFO_DEPTH, 64, words per channel FIFO (power of 2, >= 2^(BW-ADDR_W)).
ADDR_W, $clog2(NUM_CH), derived; header address field width.
LEN_W, BW-ADDR_W, derived; header length field width.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
packet_valid  input  1  high for every word of a packet (header, payload, parity)
data_in  input  BW  stream word, sampled when packet_valid=1
rd_en  input  NUM_CH  per-channel pop; ignored when that channel is empty
dout  output  NUM_CH*BW  per-channel head word, first-word-fall-through; ch k at [k*BW +: BW]
vld_out  output  NUM_CH  channel k holds at least one committed word
err  output  1  one-cycle pulse on parity mismatch
drop_cnt  output  16  packets discarded, saturating at 16'hFFFF
pkt_cnt  output  16  packets committed, wraps

Behaviour:
- Reset (async assert, sync release):
  - FSM returns to IDLE.
  - All FIFO pointers and shadow pointers go to 0, so `vld_out` is 0.
  - `dout` is 0, `err` is 0, `drop_cnt` is 0, `pkt_cnt` is 0.
  - Any partial packet is lost.
- Header format: `addr = data_in[ADDR_W-1:0]`, `len = data_in[BW-1:ADDR_W]`.
- Packet length on the wire: len+2 cycles with `packet_valid` continuously high (header, len payload words, parity word).
- Parity: XOR of the header and all payload words must equal the parity word.
- FSM states: IDLE, PAYLOAD, PARITY, DROP.
- IDLE:
  - On `packet_valid`=1, latch addr and len, and load the parity accumulator with the header.
  - Go to DROP and increment `drop_cnt` if any of these holds: `len`=0, `addr`>=NUM_CH, or channel free space < len+1.
  - Otherwise write the header at the shadow write pointer and go to PAYLOAD.
- PAYLOAD:
  - Each valid word is written at the shadow pointer and XORed into the accumulator.
  - After the len-th word, go to PARITY.
- PARITY, on a valid word:
  - On match, set committed wptr := shadow wptr, increment `pkt_cnt`, and go to IDLE.
  - On mismatch, pulse `err` the next cycle, and still commit (default build).
- Abort: `packet_valid`=0 while in PAYLOAD or PARITY:
  - Restore shadow := committed wptr.
  - Increment `drop_cnt`.
  - Go to IDLE. No words become visible.
- DROP: consume words until `packet_valid`=0, then go to IDLE. Nothing is written.
- Back-to-back packets: a valid word in the cycle after the parity word is a new header. IDLE must therefore accept a header in the same cycle the FSM enters IDLE; there are no gap cycles.
- Latency: `vld_out[k]` rises the cycle after the parity word is sampled.
- FIFO read side:
  - `dout` always shows the head word.
  - `rd_en` with `vld_out`=1 advances the read pointer.
  - `vld_out` uses committed wptr only, so readers never see uncommitted words.
- Simultaneous read and write on the same channel is allowed.
  - Free space for the admission check is computed from the committed read pointer at header time.
  - Reads during reception only increase space, so overflow is impossible.
- Pointers are log2(FIFO_DEPTH)+1 bits, wrap-around; full/empty use the MSB compare.
- `drop_cnt` holds at FFFF. `pkt_cnt` wraps FFFF->0.

Optional Feature:
DATAIN_PARITY_DROP_EN:
- Defined: a parity mismatch pulses `err`, rolls back the shadow pointer and increments `drop_cnt`. The packet is discarded and `pkt_cnt` is unchanged.
- Undefined: a mismatched packet is committed with the `err` pulse (default behaviour above).

Test Plan:
- BW=8, NUM_CH=3. Stream 0D,AA,BB,CC,D0 → ch1 holds 0D,AA,BB,CC. `vld_out[1]`=1 one cycle after D0; `err`=0; `pkt_cnt`=1.
- Same packet with parity 00 → `err` pulses once. Default build commits 4 words; with DATAIN_PARITY_DROP_EN, ch1 stays empty and `drop_cnt`=1.
- Header 0F (addr 3, invalid), then 3 more words → nothing written; `drop_cnt`=1; FSM back to IDLE after `packet_valid` falls.
- Header 09 (len 2, addr 1), payload 11, then `packet_valid`=0 → abort; `vld_out[1]` stays 0; `drop_cnt`=1. A following 0D packet lands at FIFO address 0.
- Two back-to-back packets to ch0 and ch2 with no gap; read ch0 with `rd_en` during the second packet → both committed; `pkt_cnt`=2; ch0 drains in order.
- Fill ch0 with 60 words, then header FC (len 63) → dropped for insufficient space. Reset asserted mid-packet → all `vld_out`=0 and counters 0 immediately.

Source files
------------

// File: rtl/datain_pkt_rx.sv
// datain_pkt_rx: packet receiver for the datain stream.
// Parses a header {len, addr}, buffers header+payload into one of NUM_CH
// first-word-fall-through FIFOs and commits the packet only after the
// trailing parity word, so readers only ever see whole packets.
// Optional build macro: DATAIN_PARITY_DROP_EN (discard packets whose parity
// mismatches instead of committing them with an err pulse).
module datain_pkt_rx #(
   parameter int BW         = 8,
   parameter int NUM_CH     = 3,
   parameter int FIFO_DEPTH = 64,
   parameter int ADDR_W     = $clog2(NUM_CH),
   parameter int LEN_W      = BW - ADDR_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 packet_valid,
   input  logic [BW-1:0]        data_in,
   input  logic [NUM_CH-1:0]    rd_en,
   output logic [NUM_CH*BW-1:0] dout,
   output logic [NUM_CH-1:0]    vld_out,
   output logic                 err,
   output logic [15:0]          drop_cnt,
   output logic [15:0]          pkt_cnt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
   localparam int IDX_W = PTR_W - 1;
   localparam int CMP_W = (PTR_W > LEN_W + 1) ? PTR_W : LEN_W + 1;

   typedef enum logic [1:0] {IDLE, PAYLOAD, PARITY, DROP} state_t;

   state_t             state_r, state_nx;
   logic [ADDR_W-1:0]  addr_r;
   logic [LEN_W-1:0]   len_r;
   logic [LEN_W-1:0]   cnt_r;
   logic [BW-1:0]      acc_r;
   logic [PTR_W-1:0]   swptr_r [NUM_CH];
   logic [PTR_W-1:0]   cwptr_r [NUM_CH];
   logic [PTR_W-1:0]   rptr_r  [NUM_CH];
   logic [BW-1:0]      mem     [NUM_CH][FIFO_DEPTH];
   logic               err_r;
   logic [15:0]        drop_cnt_r;
   logic [15:0]        pkt_cnt_r;

   logic [ADDR_W-1:0]  hdr_addr_s;
   logic [LEN_W-1:0]   hdr_len_s;
   logic [CMP_W-1:0]   free_s;
   logic [CMP_W-1:0]   need_s;
   logic               hdr_bad_s;
   logic               wr_en_s;
   logic [ADDR_W-1:0]  wr_ch_s;
   logic               commit_s;
   logic               rollback_s;
   logic               drop_inc_s;
   logic               pkt_inc_s;
   logic               err_s;
   logic [NUM_CH-1:0]  vld_s;

   assign hdr_addr_s = data_in[ADDR_W-1:0];
   assign hdr_len_s  = data_in[BW-1:ADDR_W];

   // Header admission: free space of the addressed channel against len+1 words.
   always_comb begin
      free_s = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (hdr_addr_s == ADDR_W'(k)) begin
            free_s = CMP_W'(PTR_W'(FIFO_DEPTH) - (cwptr_r[k] - rptr_r[k]));
         end else begin
            free_s = free_s;
         end
      end
      need_s    = CMP_W'(hdr_len_s) + CMP_W'(1);
      hdr_bad_s = (hdr_len_s == '0) ||
                  ({1'b0, hdr_addr_s} >= (ADDR_W + 1)'(NUM_CH)) ||
                  (free_s < need_s);
   end

   // Next-state and per-cycle control strobes of the receive FSM.
   always_comb begin
      state_nx   = state_r;
      wr_en_s    = 1'b0;
      wr_ch_s    = addr_r;
      commit_s   = 1'b0;
      rollback_s = 1'b0;
      drop_inc_s = 1'b0;
      pkt_inc_s  = 1'b0;
      err_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (packet_valid) begin
               wr_ch_s = hdr_addr_s;
               if (hdr_bad_s) begin
                  drop_inc_s = 1'b1;
                  state_nx   = DROP;
               end else begin
                  wr_en_s  = 1'b1;
                  state_nx = PAYLOAD;
               end
            end else begin
               state_nx = IDLE;
            end
         end
         PAYLOAD: begin
            if (packet_valid) begin
               wr_en_s = 1'b1;
               if (cnt_r == len_r - LEN_W'(1)) begin
                  state_nx = PARITY;
               end else begin
                  state_nx = PAYLOAD;
               end
            end else begin
               rollback_s = 1'b1;
               drop_inc_s = 1'b1;
               state_nx   = IDLE;
            end
         end
         PARITY: begin
            if (packet_valid) begin
               state_nx = IDLE;
               if (acc_r == data_in) begin
                  commit_s  = 1'b1;
                  pkt_inc_s = 1'b1;
               end else begin
                  err_s = 1'b1;
`ifdef DATAIN_PARITY_DROP_EN
                  rollback_s = 1'b1;
                  drop_inc_s = 1'b1;
`else
                  commit_s  = 1'b1;
                  pkt_inc_s = 1'b1;
`endif
               end
            end else begin
               rollback_s = 1'b1;
               drop_inc_s = 1'b1;
               state_nx   = IDLE;
            end
         end
         DROP: begin
            if (packet_valid) begin
               state_nx = DROP;
            end else begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // FSM state, header fields, payload counter and parity accumulator.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         addr_r  <= '0;
         len_r   <= '0;
         cnt_r   <= '0;
         acc_r   <= '0;
      end else begin
         state_r <= state_nx;
         if (state_r == IDLE && packet_valid) begin
            addr_r <= hdr_addr_s;
            len_r  <= hdr_len_s;
            cnt_r  <= '0;
            acc_r  <= data_in;
         end else if (state_r == PAYLOAD && packet_valid) begin
            cnt_r <= cnt_r + LEN_W'(1);
            acc_r <= acc_r ^ data_in;
         end else begin
            acc_r <= acc_r;
         end
      end
   end

   // Shadow/committed write pointers and read pointers per channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_CH; k++) begin
            swptr_r[k] <= '0;
            cwptr_r[k] <= '0;
            rptr_r[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (wr_en_s && wr_ch_s == ADDR_W'(k)) begin
               swptr_r[k] <= swptr_r[k] + PTR_W'(1);
            end else if (rollback_s && addr_r == ADDR_W'(k)) begin
               swptr_r[k] <= cwptr_r[k];
            end else begin
               swptr_r[k] <= swptr_r[k];
            end
            if (commit_s && addr_r == ADDR_W'(k)) begin
               cwptr_r[k] <= swptr_r[k];
            end else begin
               cwptr_r[k] <= cwptr_r[k];
            end
            if (rd_en[k] && vld_s[k]) begin
               rptr_r[k] <= rptr_r[k] + PTR_W'(1);
            end else begin
               rptr_r[k] <= rptr_r[k];
            end
         end
      end
   end

   // FIFO storage write at the shadow pointer of the target channel.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_CH; k++) begin
         if (wr_en_s && wr_ch_s == ADDR_W'(k)) begin
            mem[k][swptr_r[k][IDX_W-1:0]] <= data_in;
         end
      end
   end

   // Error pulse and packet statistics.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_r      <= 1'b0;
         drop_cnt_r <= 16'h0000;
         pkt_cnt_r  <= 16'h0000;
      end else begin
         err_r <= err_s;
         if (drop_inc_s && drop_cnt_r != 16'hFFFF) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
         end else begin
            drop_cnt_r <= drop_cnt_r;
         end
         if (pkt_inc_s) begin
            pkt_cnt_r <= pkt_cnt_r + 16'h0001;
         end else begin
            pkt_cnt_r <= pkt_cnt_r;
         end
      end
   end

   // Read side: only committed words are visible; head word falls through.
   always_comb begin
      dout = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         vld_s[k] = (cwptr_r[k] != rptr_r[k]);
         if (vld_s[k]) begin
            dout[k*BW +: BW] = mem[k][rptr_r[k][IDX_W-1:0]];
         end else begin
            dout[k*BW +: BW] = '0;
         end
      end
   end

   assign vld_out  = vld_s;
   assign err      = err_r;
   assign drop_cnt = drop_cnt_r;
   assign pkt_cnt  = pkt_cnt_r;

endmodule

// File: tb/tb_datain_pkt_rx.sv
// Directed bench for datain_pkt_rx (BW=8, NUM_CH=3, FIFO_DEPTH=64).
module tb_datain_pkt_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        packet_valid;
   logic [7:0]  data_in;
   logic [2:0]  rd_en;
   logic [23:0] dout;
   logic [2:0]  vld_out;
   logic        err;
   logic [15:0] drop_cnt;
   logic [15:0] pkt_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   datain_pkt_rx #(.BW(8), .NUM_CH(3), .FIFO_DEPTH(64)) dut (
      .clk(clk), .rst(rst), .packet_valid(packet_valid), .data_in(data_in),
      .rd_en(rd_en), .dout(dout), .vld_out(vld_out), .err(err),
      .drop_cnt(drop_cnt), .pkt_cnt(pkt_cnt)
   );

   always #5 clk = ~clk;

   task automatic send(input logic [7:0] w);
      @(negedge clk);
      packet_valid = 1'b1;
      data_in      = w;
   endtask

   task automatic gap();
      @(negedge clk);
      packet_valid = 1'b0;
      data_in      = 8'h00;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; packet_valid = 1'b0; data_in = 8'h00; rd_en = 3'b000;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (vld_out !== 3'b000 || dout !== 24'h0 || err !== 1'b0 ||
          drop_cnt !== 16'h0 || pkt_cnt !== 16'h0) begin
         n_fail++;
         $display("FAIL reset: vld=%b dout=%h err=%b drop=%h pkt=%h, want all 0",
                  vld_out, dout, err, drop_cnt, pkt_cnt);
      end
   endtask

   task automatic test_basic();
      logic [7:0] exp [4] = '{8'h0D, 8'hAA, 8'hBB, 8'hCC};
      do_reset();
      send(8'h0D); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hD0);
      n_checks++;
      if (vld_out[1] !== 1'b0) begin
         n_fail++; $display("FAIL basic_pre_commit: vld1=%b want 0", vld_out[1]);
      end
      gap();
      n_checks++;
      if (vld_out !== 3'b010 || err !== 1'b0 || pkt_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL basic_commit: vld=%b err=%b pkt=%0d want 010 0 1", vld_out, err, pkt_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (vld_out[1] !== 1'b1 || dout[15:8] !== exp[i]) begin
            n_fail++;
            $display("FAIL basic_drain[%0d]: vld=%b dout=%h want 1 %h", i, vld_out[1], dout[15:8], exp[i]);
         end
         rd_en = 3'b010;
         @(negedge clk);
      end
      rd_en = 3'b000;
      n_checks++;
      if (vld_out[1] !== 1'b0) begin
         n_fail++; $display("FAIL basic_empty: vld1=%b want 0", vld_out[1]);
      end
   endtask

   task automatic test_parity_err();
      logic [7:0] exp [4] = '{8'h0D, 8'hAA, 8'hBB, 8'hCC};
      do_reset();
      send(8'h0D); send(8'hAA); send(8'hBB); send(8'hCC); send(8'h00);
      gap();
      n_checks++;
      if (err !== 1'b1) begin
         n_fail++; $display("FAIL parity_err_pulse: err=%b want 1", err);
      end
      @(negedge clk);
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++; $display("FAIL parity_err_one_cycle: err=%b want 0", err);
      end
`ifdef DATAIN_PARITY_DROP_EN
      n_checks++;
      if (vld_out[1] !== 1'b0 || drop_cnt !== 16'd1 || pkt_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL parity_drop: vld1=%b drop=%0d pkt=%0d want 0 1 0", vld_out[1], drop_cnt, pkt_cnt);
      end
`else
      n_checks++;
      if (vld_out[1] !== 1'b1 || drop_cnt !== 16'd0 || pkt_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL parity_commit: vld1=%b drop=%0d pkt=%0d want 1 0 1", vld_out[1], drop_cnt, pkt_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (dout[15:8] !== exp[i]) begin
            n_fail++; $display("FAIL parity_drain[%0d]: dout=%h want %h", i, dout[15:8], exp[i]);
         end
         rd_en = 3'b010;
         @(negedge clk);
      end
      rd_en = 3'b000;
`endif
   endtask

   task automatic test_bad_addr();
      do_reset();
      send(8'h0F); send(8'h11); send(8'h22); send(8'h33);
      gap();
      n_checks++;
      if (vld_out !== 3'b000 || drop_cnt !== 16'd1 || pkt_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL bad_addr: vld=%b drop=%0d pkt=%0d want 000 1 0", vld_out, drop_cnt, pkt_cnt);
      end
      send(8'h0D); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hD0);
      gap();
      n_checks++;
      if (vld_out !== 3'b010 || pkt_cnt !== 16'd1 || dout[15:8] !== 8'h0D) begin
         n_fail++;
         $display("FAIL bad_addr_recover: vld=%b pkt=%0d head=%h want 010 1 0D", vld_out, pkt_cnt, dout[15:8]);
      end
   endtask

   task automatic test_abort();
      logic [7:0] exp [4] = '{8'h0D, 8'hAA, 8'hBB, 8'hCC};
      do_reset();
      send(8'h09); send(8'h11);
      gap();
      @(negedge clk);
      n_checks++;
      if (vld_out[1] !== 1'b0 || drop_cnt !== 16'd1 || pkt_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL abort: vld1=%b drop=%0d pkt=%0d want 0 1 0", vld_out[1], drop_cnt, pkt_cnt);
      end
      send(8'h0D); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hD0);
      gap();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (vld_out[1] !== 1'b1 || dout[15:8] !== exp[i]) begin
            n_fail++;
            $display("FAIL abort_drain[%0d]: vld=%b dout=%h want 1 %h", i, vld_out[1], dout[15:8], exp[i]);
         end
         rd_en = 3'b010;
         @(negedge clk);
      end
      rd_en = 3'b000;
      n_checks++;
      if (vld_out[1] !== 1'b0) begin
         n_fail++; $display("FAIL abort_empty: vld1=%b want 0", vld_out[1]);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp2 [3] = '{8'h0A, 8'h33, 8'h44};
      do_reset();
      send(8'h08); send(8'h01); send(8'h02); send(8'h0B);
      send(8'h0A);
      n_checks++;
      if (vld_out[0] !== 1'b1 || dout[7:0] !== 8'h08) begin
         n_fail++; $display("FAIL b2b_ch0_head: vld0=%b dout=%h want 1 08", vld_out[0], dout[7:0]);
      end
      rd_en = 3'b001;
      send(8'h33);
      n_checks++;
      if (dout[7:0] !== 8'h01) begin
         n_fail++; $display("FAIL b2b_ch0_w1: dout=%h want 01", dout[7:0]);
      end
      send(8'h44);
      n_checks++;
      if (dout[7:0] !== 8'h02) begin
         n_fail++; $display("FAIL b2b_ch0_w2: dout=%h want 02", dout[7:0]);
      end
      send(8'h7D);
      rd_en = 3'b000;
      n_checks++;
      if (vld_out[0] !== 1'b0) begin
         n_fail++; $display("FAIL b2b_ch0_empty: vld0=%b want 0", vld_out[0]);
      end
      gap();
      n_checks++;
      if (vld_out !== 3'b100 || pkt_cnt !== 16'd2 || drop_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL b2b_commit: vld=%b pkt=%0d drop=%0d want 100 2 0", vld_out, pkt_cnt, drop_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (dout[23:16] !== exp2[i]) begin
            n_fail++; $display("FAIL b2b_ch2_drain[%0d]: dout=%h want %h", i, dout[23:16], exp2[i]);
         end
         rd_en = 3'b100;
         @(negedge clk);
      end
      rd_en = 3'b000;
   endtask

   task automatic test_full();
      logic [7:0] acc;
      logic [7:0] exp_q [$];
      do_reset();
      acc = 8'hEC;
      exp_q.push_back(8'hEC);
      send(8'hEC);
      for (int i = 1; i <= 59; i++) begin
         send(8'(i));
         acc = acc ^ 8'(i);
         exp_q.push_back(8'(i));
      end
      send(acc);
      gap();
      n_checks++;
      if (vld_out[0] !== 1'b1 || pkt_cnt !== 16'd1) begin
         n_fail++; $display("FAIL full_fill: vld0=%b pkt=%0d want 1 1", vld_out[0], pkt_cnt);
      end
      send(8'hFC);
      for (int i = 0; i < 64; i++) send(8'h55);
      gap();
      n_checks++;
      if (drop_cnt !== 16'd1 || pkt_cnt !== 16'd1) begin
         n_fail++; $display("FAIL full_drop: drop=%0d pkt=%0d want 1 1", drop_cnt, pkt_cnt);
      end
      send(8'h0C); send(8'h01); send(8'h02); send(8'h03); send(8'h0C);
      gap();
      n_checks++;
      if (pkt_cnt !== 16'd2 || drop_cnt !== 16'd1) begin
         n_fail++; $display("FAIL full_exact_fit: pkt=%0d drop=%0d want 2 1", pkt_cnt, drop_cnt);
      end
      exp_q.push_back(8'h0C); exp_q.push_back(8'h01);
      exp_q.push_back(8'h02); exp_q.push_back(8'h03);
      for (int i = 0; i < 64; i++) begin
         n_checks++;
         if (vld_out[0] !== 1'b1 || dout[7:0] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL full_drain[%0d]: vld=%b dout=%h want 1 %h", i, vld_out[0], dout[7:0], exp_q[i]);
         end
         rd_en = 3'b001;
         @(negedge clk);
      end
      rd_en = 3'b000;
      n_checks++;
      if (vld_out[0] !== 1'b0) begin
         n_fail++; $display("FAIL full_empty: vld0=%b want 0", vld_out[0]);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      send(8'h0D); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hD0);
      gap();
      n_checks++;
      if (vld_out[1] !== 1'b1 || pkt_cnt !== 16'd1) begin
         n_fail++; $display("FAIL rmid_pre: vld1=%b pkt=%0d want 1 1", vld_out[1], pkt_cnt);
      end
      send(8'h0D); send(8'hAA);
      #2;
      rst = 1'b1;
      packet_valid = 1'b0;
      #1;
      n_checks++;
      if (vld_out !== 3'b000 || pkt_cnt !== 16'd0 || drop_cnt !== 16'd0 ||
          err !== 1'b0 || dout !== 24'h0) begin
         n_fail++;
         $display("FAIL rmid_async: vld=%b pkt=%0d drop=%0d err=%b dout=%h want all 0",
                  vld_out, pkt_cnt, drop_cnt, err, dout);
      end
      @(negedge clk);
      rst = 1'b0;
      send(8'h0D); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hD0);
      gap();
      n_checks++;
      if (vld_out !== 3'b010 || pkt_cnt !== 16'd1 || dout[15:8] !== 8'h0D) begin
         n_fail++;
         $display("FAIL rmid_after: vld=%b pkt=%0d head=%h want 010 1 0D", vld_out, pkt_cnt, dout[15:8]);
      end
   endtask

   initial begin
      rst = 1'b1; packet_valid = 1'b0; data_in = 8'h00; rd_en = 3'b000;
      test_reset();
      test_basic();
      test_parity_err();
      test_bad_addr();
      test_abort();
      test_back_to_back();
      test_full();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
